// File: rtl/wb_pipe_reg_pkg.sv
// Shared constants for the MEM/WB stage register and its counters.
//   RstEnable/WriteEnable/WriteDisable/Stop/NoStop : 1-bit control levels
//   ZeroWord/NOPRegAddr                           : payload clear values
//   CNT_W_DEFAULT                                 : default perf counter width
//   wb_act_e                                      : per-edge stage action
package wb_pipe_reg_pkg;

  localparam logic        RstEnable    = 1'b1;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic        Stop         = 1'b1;
  localparam logic        NoStop       = 1'b0;
  localparam logic [31:0] ZeroWord     = 32'h0;
  localparam logic [4:0]  NOPRegAddr   = 5'b00000;

  localparam int unsigned CNT_W_DEFAULT = 16;

  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_FLUSH,
    ACT_BUBBLE,
    ACT_HOLD,
    ACT_ADVANCE
  } wb_act_e;

endpackage

// File: rtl/wb_pipe_reg_sat_counter.sv
// Saturating up-counter: counts inc pulses, sticks at all-ones.
//   clk : clock
//   rst : synchronous active-high clear
//   inc : count enable
//   cnt : current count
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  import wb_pipe_reg_pkg::*;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) cnt_q <= '0;
    else                  cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/wb_pipe_reg.sv
// MEM/WB pipeline register with NUM_CH regfile write channels, HI/LO and
// LLbit write-back, flush, valid bit, same-address collision resolution and
// saturating hold/bubble counters. All outputs are registered.
//   clk, rst (sync, active-high), stall vector, flush
//   mem_* : bundle from the memory-access stage
//   wb_*  : registered bundle to write-back
//   hold_cnt / bubble_cnt : saturating performance counters
module wb_pipe_reg
  import wb_pipe_reg_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned NUM_CH    = 1,
  parameter int unsigned STALL_W   = 6,
  parameter int unsigned STALL_IDX = 4,
  parameter int unsigned CNT_W     = CNT_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [STALL_W-1:0]       stall,
  input  logic                     flush,
  input  logic                     mem_valid,
  input  logic [NUM_CH*ADDR_W-1:0] mem_wd,
  input  logic [NUM_CH-1:0]        mem_wreg,
  input  logic [NUM_CH*DATA_W-1:0] mem_wdata,
  input  logic                     mem_whilo,
  input  logic [DATA_W-1:0]        mem_hi,
  input  logic [DATA_W-1:0]        mem_lo,
  input  logic                     mem_llbit_we,
  input  logic                     mem_llbit_value,
  output logic                     wb_valid,
  output logic [NUM_CH*ADDR_W-1:0] wb_wd,
  output logic [NUM_CH-1:0]        wb_wreg,
  output logic [NUM_CH*DATA_W-1:0] wb_wdata,
  output logic                     wb_whilo,
  output logic [DATA_W-1:0]        wb_hi,
  output logic [DATA_W-1:0]        wb_lo,
  output logic                     wb_llbit_we,
  output logic                     wb_llbit_value,
  output logic [CNT_W-1:0]         hold_cnt,
  output logic [CNT_W-1:0]         bubble_cnt
);

  logic stop_here;
  logic stop_next;

  assign stop_here = stall[STALL_IDX];

  // The last stage has no downstream stall bit; treat it as never stopped.
  if (STALL_IDX + 1 < STALL_W) begin : g_next
    assign stop_next = stall[STALL_IDX+1];
  end else begin : g_no_next
    assign stop_next = NoStop;
  end

  wb_act_e act;

  always_comb begin
    act = ACT_ADVANCE;
    if (rst == RstEnable)                           act = ACT_RESET;
    else if (flush)                                 act = ACT_FLUSH;
    else if (stop_here == Stop && stop_next == NoStop) act = ACT_BUBBLE;
    else if (stop_here == Stop && stop_next == Stop)   act = ACT_HOLD;
  end

  // Write-enable sanitiser: drop r0 writes, invalid bundles, and any channel
  // overwritten by a higher-index channel to the same address in this bundle.
  logic [NUM_CH-1:0] wreg_san;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_san
    logic kill;
    always_comb begin
      kill = 1'b0;
      for (int unsigned j = i + 1; j < NUM_CH; j++) begin
        if (mem_wreg[j] && (mem_wd[j*ADDR_W +: ADDR_W] == mem_wd[i*ADDR_W +: ADDR_W]))
          kill = 1'b1;
      end
    end
    assign wreg_san[i] = mem_valid && mem_wreg[i] && !kill &&
                         (mem_wd[i*ADDR_W +: ADDR_W] != '0);
  end

  logic                     valid_q;
  logic [NUM_CH*ADDR_W-1:0] wd_q;
  logic [NUM_CH-1:0]        wreg_q;
  logic [NUM_CH*DATA_W-1:0] wdata_q;
  logic                     whilo_q;
  logic [DATA_W-1:0]        hi_q;
  logic [DATA_W-1:0]        lo_q;
  logic                     llbit_we_q;
  logic                     llbit_value_q;

  always_ff @(posedge clk) begin
    case (act)
      ACT_RESET, ACT_FLUSH, ACT_BUBBLE: begin
        valid_q       <= 1'b0;
        wd_q          <= '0;
        wreg_q        <= '0;
        wdata_q       <= '0;
        whilo_q       <= WriteDisable;
        hi_q          <= '0;
        lo_q          <= '0;
        llbit_we_q    <= WriteDisable;
        llbit_value_q <= 1'b0;
      end
      ACT_HOLD: ;
      default: begin
        valid_q       <= mem_valid;
        wd_q          <= mem_wd;
        wreg_q        <= wreg_san;
        wdata_q       <= mem_wdata;
        whilo_q       <= mem_valid && mem_whilo;
        hi_q          <= mem_hi;
        lo_q          <= mem_lo;
        llbit_we_q    <= mem_valid && mem_llbit_we;
        llbit_value_q <= mem_llbit_value;
      end
    endcase
  end

  assign wb_valid       = valid_q;
  assign wb_wd          = wd_q;
  assign wb_wreg        = wreg_q;
  assign wb_wdata       = wdata_q;
  assign wb_whilo       = whilo_q;
  assign wb_hi          = hi_q;
  assign wb_lo          = lo_q;
  assign wb_llbit_we    = llbit_we_q;
  assign wb_llbit_value = llbit_value_q;

  sat_counter #(.W(CNT_W)) u_hold_cnt (
    .clk (clk),
    .rst (rst),
    .inc (act == ACT_HOLD),
    .cnt (hold_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc (act == ACT_BUBBLE),
    .cnt (bubble_cnt)
  );

endmodule

// File: tb/tb_wb_pipe_reg.sv
module tb_wb_pipe_reg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned NUM_CH  = 2;
  localparam int unsigned STALL_W = 6;
  localparam int unsigned CNT_W   = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [STALL_W-1:0]       stall;
  logic                     flush;
  logic                     mem_valid;
  logic [NUM_CH*ADDR_W-1:0] mem_wd;
  logic [NUM_CH-1:0]        mem_wreg;
  logic [NUM_CH*DATA_W-1:0] mem_wdata;
  logic                     mem_whilo;
  logic [DATA_W-1:0]        mem_hi;
  logic [DATA_W-1:0]        mem_lo;
  logic                     mem_llbit_we;
  logic                     mem_llbit_value;
  logic                     wb_valid;
  logic [NUM_CH*ADDR_W-1:0] wb_wd;
  logic [NUM_CH-1:0]        wb_wreg;
  logic [NUM_CH*DATA_W-1:0] wb_wdata;
  logic                     wb_whilo;
  logic [DATA_W-1:0]        wb_hi;
  logic [DATA_W-1:0]        wb_lo;
  logic                     wb_llbit_we;
  logic                     wb_llbit_value;
  logic [CNT_W-1:0]         hold_cnt;
  logic [CNT_W-1:0]         bubble_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_pipe_reg #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_CH   (NUM_CH),
    .STALL_W  (STALL_W),
    .STALL_IDX(4),
    .CNT_W    (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .mem_valid      (mem_valid),
    .mem_wd         (mem_wd),
    .mem_wreg       (mem_wreg),
    .mem_wdata      (mem_wdata),
    .mem_whilo      (mem_whilo),
    .mem_hi         (mem_hi),
    .mem_lo         (mem_lo),
    .mem_llbit_we   (mem_llbit_we),
    .mem_llbit_value(mem_llbit_value),
    .wb_valid       (wb_valid),
    .wb_wd          (wb_wd),
    .wb_wreg        (wb_wreg),
    .wb_wdata       (wb_wdata),
    .wb_whilo       (wb_whilo),
    .wb_hi          (wb_hi),
    .wb_lo          (wb_lo),
    .wb_llbit_we    (wb_llbit_we),
    .wb_llbit_value (wb_llbit_value),
    .hold_cnt       (hold_cnt),
    .bubble_cnt     (bubble_cnt)
  );

  // Advance one edge and sample just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; stall = '0;
    mem_valid = 1'b1; mem_wd = {5'd0, 5'd3}; mem_wreg = 2'b01;
    mem_wdata = {32'h0, 32'hDEADBEEF}; mem_whilo = 1'b1;
    mem_hi = 32'h1; mem_lo = 32'h2; mem_llbit_we = 1'b1; mem_llbit_value = 1'b1;
    step(); step();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", wb_valid); end
    checks++; if (wb_wd !== 10'h0) begin errors++; $display("FAIL reset_wd: got %h expected 0", wb_wd); end
    checks++; if (wb_wreg !== 2'b00) begin errors++; $display("FAIL reset_wreg: got %b expected 00", wb_wreg); end
    checks++; if (wb_wdata !== 64'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", wb_wdata); end
    checks++; if ({wb_whilo, wb_llbit_we, wb_llbit_value} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b expected 000", {wb_whilo, wb_llbit_we, wb_llbit_value}); end
    checks++; if ({wb_hi, wb_lo} !== 64'h0) begin errors++; $display("FAIL reset_hilo: got %h expected 0", {wb_hi, wb_lo}); end
    checks++; if ({hold_cnt, bubble_cnt} !== 8'h00) begin errors++; $display("FAIL reset_cnt: got %h expected 00", {hold_cnt, bubble_cnt}); end
    rst = 1'b0;
  endtask

  task automatic test_advance();
    mem_valid = 1'b1; mem_wd = {5'd0, 5'd5}; mem_wreg = 2'b01;
    mem_wdata = {32'h0, 32'h12345678}; mem_whilo = 1'b1;
    mem_hi = 32'hA; mem_lo = 32'hB; mem_llbit_we = 1'b1; mem_llbit_value = 1'b1;
    step();
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL adv_valid: got %b expected 1", wb_valid); end
    checks++; if (wb_wd !== {5'd0, 5'd5}) begin errors++; $display("FAIL adv_wd: got %h expected 005", wb_wd); end
    checks++; if (wb_wreg !== 2'b01) begin errors++; $display("FAIL adv_wreg: got %b expected 01", wb_wreg); end
    checks++; if (wb_wdata !== 64'h0000_0000_1234_5678) begin errors++; $display("FAIL adv_wdata: got %h expected 12345678", wb_wdata); end
    checks++; if ({wb_hi, wb_lo} !== {32'hA, 32'hB}) begin errors++; $display("FAIL adv_hilo: got %h/%h expected a/b", wb_hi, wb_lo); end
    checks++; if ({wb_whilo, wb_llbit_we, wb_llbit_value} !== 3'b111) begin errors++; $display("FAIL adv_ctrl: got %b expected 111", {wb_whilo, wb_llbit_we, wb_llbit_value}); end
  endtask

  task automatic test_bubble_hold();
    stall = 6'b010000;
    step();
    checks++; if ({wb_valid, wb_wreg, wb_whilo} !== 4'b0000) begin errors++; $display("FAIL bubble_ctrl: got %b expected 0000", {wb_valid, wb_wreg, wb_whilo}); end
    checks++; if ({wb_wdata, wb_hi} !== 96'h0) begin errors++; $display("FAIL bubble_payload: got %h expected 0", {wb_wdata, wb_hi}); end
    checks++; if ({hold_cnt, bubble_cnt} !== 8'h01) begin errors++; $display("FAIL bubble_cnt: got %h expected 01", {hold_cnt, bubble_cnt}); end
    // Load a fresh bundle so a hold has something non-zero to freeze.
    stall = '0;
    mem_wd = {5'd0, 5'd9}; mem_wreg = 2'b01; mem_wdata = {32'h0, 32'hCAFEF00D};
    mem_whilo = 1'b0; mem_hi = 32'h1; mem_lo = 32'h2; mem_llbit_we = 1'b0; mem_llbit_value = 1'b0;
    step();
    checks++; if (wb_wdata !== 64'h0000_0000_CAFE_F00D) begin errors++; $display("FAIL load_wdata: got %h expected cafef00d", wb_wdata); end
    stall = 6'b110000;
    for (int i = 0; i < 3; i++) begin
      mem_wd = {5'd4, 5'(i + 10)}; mem_wreg = 2'b11; mem_wdata = {32'(i), 32'(i + 100)};
      mem_whilo = 1'b1; mem_hi = 32'(i); mem_lo = 32'(i);
      step();
    end
    checks++; if ({wb_valid, wb_wreg, wb_whilo} !== 4'b1010) begin errors++; $display("FAIL hold_ctrl: got %b expected 1010", {wb_valid, wb_wreg, wb_whilo}); end
    checks++; if (wb_wd !== {5'd0, 5'd9}) begin errors++; $display("FAIL hold_wd: got %h expected 009", wb_wd); end
    checks++; if (wb_wdata !== 64'h0000_0000_CAFE_F00D) begin errors++; $display("FAIL hold_wdata: got %h expected cafef00d", wb_wdata); end
    checks++; if ({wb_hi, wb_lo} !== {32'h1, 32'h2}) begin errors++; $display("FAIL hold_hilo: got %h/%h expected 1/2", wb_hi, wb_lo); end
    checks++; if ({hold_cnt, bubble_cnt} !== 8'h31) begin errors++; $display("FAIL hold_cnt: got %h expected 31", {hold_cnt, bubble_cnt}); end
  endtask

  task automatic test_flush();
    flush = 1'b1; stall = 6'b110000;
    step();
    checks++; if ({wb_valid, wb_wreg} !== 3'b000) begin errors++; $display("FAIL flush_ctrl: got %b expected 000", {wb_valid, wb_wreg}); end
    checks++; if ({wb_wd, wb_wdata, wb_hi, wb_lo} !== 138'h0) begin errors++; $display("FAIL flush_payload: got %h expected 0", {wb_wd, wb_wdata, wb_hi, wb_lo}); end
    checks++; if ({hold_cnt, bubble_cnt} !== 8'h31) begin errors++; $display("FAIL flush_cnt: got %h expected 31", {hold_cnt, bubble_cnt}); end
    flush = 1'b0; stall = '0;
  endtask

  task automatic test_collision();
    mem_valid = 1'b1; mem_whilo = 1'b0; mem_llbit_we = 1'b0;
    mem_wd = {5'd7, 5'd7}; mem_wreg = 2'b11; mem_wdata = {32'd2, 32'd1};
    step();
    checks++; if (wb_wreg !== 2'b10) begin errors++; $display("FAIL coll_wreg: got %b expected 10", wb_wreg); end
    checks++; if (wb_wdata !== {32'd2, 32'd1}) begin errors++; $display("FAIL coll_wdata: got %h expected 0000000200000001", wb_wdata); end
    mem_wd = {5'd5, 5'd0}; mem_wreg = 2'b11;
    step();
    checks++; if (wb_wreg !== 2'b10) begin errors++; $display("FAIL r0_wreg: got %b expected 10", wb_wreg); end
    mem_wd = {5'd4, 5'd3}; mem_wreg = 2'b11;
    step();
    checks++; if (wb_wreg !== 2'b11) begin errors++; $display("FAIL distinct_wreg: got %b expected 11", wb_wreg); end
    mem_wd = {5'd7, 5'd7}; mem_wreg = 2'b01;
    step();
    checks++; if (wb_wreg !== 2'b01) begin errors++; $display("FAIL nocoll_wreg: got %b expected 01", wb_wreg); end
  endtask

  task automatic test_invalid();
    mem_valid = 1'b0; mem_wd = {5'd2, 5'd1}; mem_wreg = 2'b11;
    mem_wdata = {32'h55, 32'h66}; mem_whilo = 1'b1; mem_llbit_we = 1'b1; mem_llbit_value = 1'b1;
    step();
    checks++; if ({wb_valid, wb_wreg, wb_whilo, wb_llbit_we} !== 5'b00000) begin errors++; $display("FAIL inv_ctrl: got %b expected 00000", {wb_valid, wb_wreg, wb_whilo, wb_llbit_we}); end
    checks++; if ({wb_wd, wb_wdata} !== {5'd2, 5'd1, 32'h55, 32'h66}) begin errors++; $display("FAIL inv_data: got %h expected registered data", {wb_wd, wb_wdata}); end
  endtask

  task automatic test_illegal_stall();
    stall = 6'b100000; mem_valid = 1'b1; mem_wd = {5'd0, 5'd6}; mem_wreg = 2'b01;
    mem_wdata = {32'h0, 32'h77};
    step();
    checks++; if ({wb_valid, wb_wreg, wb_wdata} !== {1'b1, 2'b01, 64'h77}) begin errors++; $display("FAIL illegal_adv: got %h expected advance", {wb_valid, wb_wreg, wb_wdata}); end
  endtask

  task automatic test_saturation();
    // Reset applied while stalled and flushing must still clear everything.
    rst = 1'b1; flush = 1'b1; stall = 6'b110000;
    step();
    checks++; if ({hold_cnt, bubble_cnt, wb_valid} !== 9'h0) begin errors++; $display("FAIL rst_mid: got %h expected 0", {hold_cnt, bubble_cnt, wb_valid}); end
    rst = 1'b0; flush = 1'b0;
    for (int i = 0; i < 14; i++) step();
    checks++; if (hold_cnt !== 4'd14) begin errors++; $display("FAIL sat_14: got %0d expected 14", hold_cnt); end
    for (int i = 0; i < 6; i++) step();
    checks++; if (hold_cnt !== 4'd15) begin errors++; $display("FAIL sat_20: got %0d expected 15", hold_cnt); end
    step();
    checks++; if ({hold_cnt, bubble_cnt} !== 8'hF0) begin errors++; $display("FAIL sat_stay: got %h expected f0", {hold_cnt, bubble_cnt}); end
    stall = '0;
  endtask

  initial begin
    test_reset();
    test_advance();
    test_bubble_hold();
    test_flush();
    test_collision();
    test_invalid();
    test_illegal_stall();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
